// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU, branch resolution and an iterative
// 32-cycle shift-add MULTU unit that stalls the upstream pipe while it runs.
module ex_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  ALU_ctrl_in,
    input  logic [1:0]  ALUSrc_in,
    input  logic [31:0] ALUOperand1_in,
    input  logic [31:0] ALUOperand2_in,
    input  logic [31:0] sign_ext_imm_in,
    input  logic [31:0] zero_ext_imm_in,
    input  logic [31:0] upper_imm_in,
    input  logic [4:0]  shamt_in,
    input  logic [4:0]  RT_in,
    input  logic [4:0]  RD_in,
    input  logic        RegDst_in,
    input  logic [31:0] pc_plus_4_in,
    input  logic        Branch_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic [1:0]  fwd_a_sel,
    input  logic [1:0]  fwd_b_sel,
    input  logic [31:0] ex_mem_fwd_data,
    input  logic [31:0] mem_wb_fwd_data,
    output logic [31:0] alu_result_out,
    output logic [31:0] write_data_out,
    output logic [31:0] branch_target_out,
    output logic [4:0]  write_reg_out,
    output logic        branch_taken_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic        stall_out
);
    localparam logic [3:0] OP_MULTU = 4'b1011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [32:0] step_sum;

    logic [31:0] alu_result_q, alu_result_d, write_data_q, write_data_d;
    logic [31:0] branch_target_q, branch_target_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic        branch_taken_q, branch_taken_d, mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d, reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;

    logic [31:0] op_a, op_bfwd, op_b, result;

    always_comb begin
        case (fwd_a_sel)
            2'b01:   op_a = ex_mem_fwd_data;
            2'b10:   op_a = mem_wb_fwd_data;
            default: op_a = ALUOperand1_in;
        endcase
        case (fwd_b_sel)
            2'b01:   op_bfwd = ex_mem_fwd_data;
            2'b10:   op_bfwd = mem_wb_fwd_data;
            default: op_bfwd = ALUOperand2_in;
        endcase
        case (ALUSrc_in)
            2'b01:   op_b = sign_ext_imm_in;
            2'b10:   op_b = zero_ext_imm_in;
            2'b11:   op_b = upper_imm_in;
            default: op_b = op_bfwd;
        endcase
    end

    always_comb begin
        result = '0;
        case (ALU_ctrl_in)
            4'b0000: result = op_a & op_b;
            4'b0001: result = op_a | op_b;
            4'b0010: result = op_a + op_b;
            4'b0011: result = op_a ^ op_b;
            4'b0100: result = ~(op_a | op_b);
            4'b0101: result = op_b << shamt_in;
            4'b1000: result = op_b >> shamt_in;
            4'b1001: result = 32'($signed(op_b) >>> shamt_in);
            4'b0110: result = op_a - op_b;
            4'b0111: result = {31'd0, $signed(op_a) < $signed(op_b)};
            4'b1010: result = {31'd0, op_a < op_b};
            4'b1100: result = hi_q;
            4'b1101: result = lo_q;
            4'b1110: result = op_b;
            default: result = '0;
        endcase
    end

    // An IDLE MULTU stalls in the same cycle it is presented, but not under reset.
    assign stall_out = reset && ((state_q == IDLE && ALU_ctrl_in == OP_MULTU) ||
                                 state_q == BUSY);

    // prod holds {partial sum, remaining multiplier bits}; one bit retires per cycle.
    assign step_sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: if (ALU_ctrl_in == OP_MULTU) begin
                mcand_d = op_a;
                prod_d  = {32'd0, op_b};
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                prod_d = {step_sum, prod_q[31:1]};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    {hi_d, lo_d} = prod_d;
                    state_d      = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_result_d    = '0;
        write_data_d    = '0;
        branch_target_d = '0;
        write_reg_d     = '0;
        branch_taken_d  = 1'b0;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        reg_write_d     = 1'b0;
        mem_to_reg_d    = 1'b0;
        if (!stall_out && state_q != DONE) begin
            alu_result_d    = result;
            write_data_d    = op_bfwd;
            branch_target_d = pc_plus_4_in + {sign_ext_imm_in[29:0], 2'b00};
            write_reg_d     = RegDst_in ? RD_in : RT_in;
            branch_taken_d  = Branch_in && (op_a == op_b);
            mem_read_d      = MemRead_in;
            mem_write_d     = MemWrite_in;
            reg_write_d     = RegWrite_in;
            mem_to_reg_d    = MemtoReg_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            mcand_q         <= '0;
            prod_q          <= '0;
            hi_q            <= '0;
            lo_q            <= '0;
            alu_result_q    <= '0;
            write_data_q    <= '0;
            branch_target_q <= '0;
            write_reg_q     <= '0;
            branch_taken_q  <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            reg_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            mcand_q         <= mcand_d;
            prod_q          <= prod_d;
            hi_q            <= hi_d;
            lo_q            <= lo_d;
            alu_result_q    <= alu_result_d;
            write_data_q    <= write_data_d;
            branch_target_q <= branch_target_d;
            write_reg_q     <= write_reg_d;
            branch_taken_q  <= branch_taken_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            reg_write_q     <= reg_write_d;
            mem_to_reg_q    <= mem_to_reg_d;
        end
    end

    assign alu_result_out    = alu_result_q;
    assign write_data_out    = write_data_q;
    assign branch_target_out = branch_target_q;
    assign write_reg_out     = write_reg_q;
    assign branch_taken_out  = branch_taken_q;
    assign MemRead_out       = mem_read_q;
    assign MemWrite_out      = mem_write_q;
    assign RegWrite_out      = reg_write_q;
    assign MemtoReg_out      = mem_to_reg_q;
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes expected register contents
// per clock edge, a monitor pops and compares after each edge.
module tb_ex_stage;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  ALU_ctrl_in;
    logic [1:0]  ALUSrc_in, fwd_a_sel, fwd_b_sel;
    logic [31:0] ALUOperand1_in, ALUOperand2_in, sign_ext_imm_in, zero_ext_imm_in;
    logic [31:0] upper_imm_in, pc_plus_4_in, ex_mem_fwd_data, mem_wb_fwd_data;
    logic [4:0]  shamt_in, RT_in, RD_in;
    logic        RegDst_in, Branch_in, MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in;
    logic [31:0] alu_result_out, write_data_out, branch_target_out;
    logic [4:0]  write_reg_out;
    logic        branch_taken_out, MemRead_out, MemWrite_out, RegWrite_out, MemtoReg_out;
    logic        stall_out;

    ex_stage dut (
        .clock(clock), .reset(reset), .ALU_ctrl_in(ALU_ctrl_in), .ALUSrc_in(ALUSrc_in),
        .ALUOperand1_in(ALUOperand1_in), .ALUOperand2_in(ALUOperand2_in),
        .sign_ext_imm_in(sign_ext_imm_in), .zero_ext_imm_in(zero_ext_imm_in),
        .upper_imm_in(upper_imm_in), .shamt_in(shamt_in), .RT_in(RT_in), .RD_in(RD_in),
        .RegDst_in(RegDst_in), .pc_plus_4_in(pc_plus_4_in), .Branch_in(Branch_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .RegWrite_in(RegWrite_in),
        .MemtoReg_in(MemtoReg_in), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .ex_mem_fwd_data(ex_mem_fwd_data), .mem_wb_fwd_data(mem_wb_fwd_data),
        .alu_result_out(alu_result_out), .write_data_out(write_data_out),
        .branch_target_out(branch_target_out), .write_reg_out(write_reg_out),
        .branch_taken_out(branch_taken_out), .MemRead_out(MemRead_out),
        .MemWrite_out(MemWrite_out), .RegWrite_out(RegWrite_out),
        .MemtoReg_out(MemtoReg_out), .stall_out(stall_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] alu, wdata, btgt;
        logic [4:0]  wreg;
        logic        bt, mr, mw, rw, m2r;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input exp_t e);
        chk({tag, " alu_result"}, alu_result_out, e.alu);
        chk({tag, " write_data"}, write_data_out, e.wdata);
        chk({tag, " branch_target"}, branch_target_out, e.btgt);
        chk({tag, " write_reg"}, {27'd0, write_reg_out}, {27'd0, e.wreg});
        chk({tag, " ctrl"}, {27'd0, branch_taken_out, MemRead_out, MemWrite_out,
                             RegWrite_out, MemtoReg_out},
            {27'd0, e.bt, e.mr, e.mw, e.rw, e.m2r});
    endtask

    exp_t mon_e;
    initial forever begin
        @(negedge clock);
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk_outs("edge", mon_e);
        end
    end

    function automatic exp_t bubble();
        exp_t e;
        e = '{alu: 32'd0, wdata: 32'd0, btgt: 32'd0, wreg: 5'd0,
              bt: 1'b0, mr: 1'b0, mw: 1'b0, rw: 1'b0, m2r: 1'b0};
        return e;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r);
        if (s == 2'd1) return ex_mem_fwd_data;
        if (s == 2'd2) return mem_wb_fwd_data;
        return r;
    endfunction

    function automatic logic [31:0] opb();
        logic [31:0] imms [4];
        imms[0] = pick(fwd_b_sel, ALUOperand2_in);
        imms[1] = sign_ext_imm_in;
        imms[2] = zero_ext_imm_in;
        imms[3] = upper_imm_in;
        return imms[ALUSrc_in];
    endfunction

    function automatic exp_t model();
        exp_t        e;
        logic [31:0] a, b, r;
        a = pick(fwd_a_sel, ALUOperand1_in);
        b = opb();
        case (int'(ALU_ctrl_in))
            0:  r = a & b;
            1:  r = a | b;
            2:  r = a + b;
            3:  r = a ^ b;
            4:  r = ~(a | b);
            5:  r = b << shamt_in;
            6:  r = a - b;
            7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            8:  r = b >> shamt_in;
            9:  r = $signed(b) >>> shamt_in;
            10: r = (a < b) ? 32'd1 : 32'd0;
            12: r = m_hi;
            13: r = m_lo;
            14: r = b;
            default: r = 32'd0;
        endcase
        e.alu   = r;
        e.wdata = pick(fwd_b_sel, ALUOperand2_in);
        e.btgt  = pc_plus_4_in + sign_ext_imm_in * 32'd4;
        e.wreg  = RegDst_in ? RD_in : RT_in;
        e.bt    = Branch_in && (a == b);
        e.mr    = MemRead_in;
        e.mw    = MemWrite_in;
        e.rw    = RegWrite_in;
        e.m2r   = MemtoReg_in;
        return e;
    endfunction

    // Entered just after a negedge with inputs driven; returns after the next negedge.
    task automatic cyc(input exp_t e, input logic exp_stall, input string tag);
        #1;
        chk({tag, " stall"}, {31'd0, stall_out}, {31'd0, exp_stall});
        sb.push_back(e);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic issue();
        cyc(model(), 1'b0, "op");
    endtask

    // 33 stalled bubbles, then one unstalled retirement bubble; abort_at<0 runs to completion.
    task automatic multu(input int abort_at);
        logic [63:0] p;
        p = {32'd0, pick(fwd_a_sel, ALUOperand1_in)} * {32'd0, opb()};
        ALU_ctrl_in = 4'b1011;
        for (int i = 0; i < 33; i++) begin
            if (i == abort_at) begin
                #2 reset = 1'b0;
                #1;
                chk("abort stall", {31'd0, stall_out}, 32'd0);
                chk_outs("abort", bubble());
                m_hi = '0;
                m_lo = '0;
                @(posedge clock);
                #2 reset = 1'b1;
                @(negedge clock);
                return;
            end
            cyc(bubble(), 1'b1, "mul");
        end
        cyc(bubble(), 1'b0, "done");
        {m_hi, m_lo} = p;
    endtask

    task automatic clear_inputs();
        {ALU_ctrl_in, ALUSrc_in, fwd_a_sel, fwd_b_sel} = '0;
        {ALUOperand1_in, ALUOperand2_in, sign_ext_imm_in, zero_ext_imm_in} = '0;
        {upper_imm_in, pc_plus_4_in, ex_mem_fwd_data, mem_wb_fwd_data} = '0;
        {shamt_in, RT_in, RD_in} = '0;
        {RegDst_in, Branch_in, MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in} = '0;
    endtask

    task automatic randomize_inputs();
        ALU_ctrl_in     = 4'($urandom);
        ALUSrc_in       = 2'($urandom);
        fwd_a_sel       = 2'($urandom);
        fwd_b_sel       = 2'($urandom);
        ALUOperand1_in  = $urandom;
        ALUOperand2_in  = ($urandom_range(0, 3) == 0) ? ALUOperand1_in : $urandom;
        sign_ext_imm_in = $urandom;
        zero_ext_imm_in = $urandom;
        upper_imm_in    = $urandom;
        pc_plus_4_in    = $urandom;
        ex_mem_fwd_data = $urandom;
        mem_wb_fwd_data = $urandom;
        shamt_in        = 5'($urandom);
        RT_in           = 5'($urandom);
        RD_in           = 5'($urandom);
        {RegDst_in, Branch_in, MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in} = 6'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        randomize_inputs();
        ALU_ctrl_in = 4'b1011;
        #12;
        chk("reset stall", {31'd0, stall_out}, 32'd0);
        chk_outs("reset", bubble());
        @(posedge clock);
        #2;
        chk_outs("reset held", bubble());
        reset = 1'b1;
        @(negedge clock);

        clear_inputs();
        ALUOperand1_in = 32'd5; ALUOperand2_in = 32'd7; ALU_ctrl_in = 4'd2; RegWrite_in = 1'b1;
        issue();

        clear_inputs();
        ALUOperand1_in = 32'h10; ALUOperand2_in = 32'h10; ALU_ctrl_in = 4'd6; Branch_in = 1'b1;
        pc_plus_4_in = 32'h100; sign_ext_imm_in = 32'hFFFF_FFFF;
        issue();

        clear_inputs();
        fwd_b_sel = 2'b01; ex_mem_fwd_data = 32'h8000_0000; shamt_in = 5'd4; ALU_ctrl_in = 4'd9;
        issue();

        clear_inputs();
        ALUOperand1_in = 32'hFFFF_FFFF; ALUOperand2_in = 32'd1;
        ALU_ctrl_in = 4'd7;  issue();
        ALU_ctrl_in = 4'd10; issue();
        ALU_ctrl_in = 4'd15; issue();

        clear_inputs();
        ALUOperand1_in = 32'hFFFF_FFFF; ALUOperand2_in = 32'd2;
        multu(-1);
        ALU_ctrl_in = 4'd12; issue();
        ALU_ctrl_in = 4'd13; issue();

        clear_inputs();
        ALUOperand1_in = 32'd3; ALUOperand2_in = 32'd5;
        multu(10);
        ALU_ctrl_in = 4'd13; issue();
        ALU_ctrl_in = 4'd12; issue();

        for (int n = 0; n < 300; n++) begin
            randomize_inputs();
            if (ALU_ctrl_in == 4'b1011) begin
                multu(-1);
                ALU_ctrl_in = ($urandom_range(0, 1) == 0) ? 4'd12 : 4'd13;
            end
            issue();
        end

        @(negedge clock);
        #1;
        chk("scoreboard drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
- REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named `clock` and `reset`, and `reset`=0 asserts.
- REQ-002 `clock` SHALL be an input, 1 bit; rising-edge clock.
- REQ-003 `reset` SHALL be an input, 1 bit; asynchronous, active-low reset.
- REQ-004 `ALU_ctrl_in` SHALL be an input, 4 bits; operation code from the ID/EX register.
- REQ-005 `ALUSrc_in` SHALL be an input, 2 bits; selects the B operand: 00 register, 01 sign-extended immediate, 10 zero-extended immediate, 11 upper immediate.
- REQ-006 `ALUOperand1_in` and `ALUOperand2_in` SHALL be inputs, 32 bits each; register-file read data.
- REQ-007 `sign_ext_imm_in`, `zero_ext_imm_in` and `upper_imm_in` SHALL be inputs, 32 bits each; immediate forms.
- REQ-008 `shamt_in`, `RT_in` and `RD_in` SHALL be inputs, 5 bits each; `RegDst_in` SHALL be an input, 1 bit.
- REQ-009 `pc_plus_4_in` SHALL be an input, 32 bits.
- REQ-010 `Branch_in`, `MemRead_in`, `MemWrite_in`, `RegWrite_in` and `MemtoReg_in` SHALL be inputs, 1 bit each; control bits to forward.
- REQ-011 `fwd_a_sel` and `fwd_b_sel` SHALL be inputs, 2 bits each; 00 register, 01 `ex_mem_fwd_data`, 10 `mem_wb_fwd_data`, 11 register.
- REQ-012 `ex_mem_fwd_data` and `mem_wb_fwd_data` SHALL be inputs, 32 bits each.
- REQ-013 `alu_result_out`, `write_data_out` and `branch_target_out` SHALL be outputs, 32 bits each, registered.
- REQ-014 `write_reg_out` SHALL be an output, 5 bits, registered.
- REQ-015 `branch_taken_out`, `MemRead_out`, `MemWrite_out`, `RegWrite_out` and `MemtoReg_out` SHALL be outputs, 1 bit each, registered.
- REQ-016 `stall_out` SHALL be an output, 1 bit, combinational; 1 = upstream holds the ID/EX contents.

Function
- REQ-017 Operand A SHALL be the `fwd_a_sel`-selected value. Operand Bfwd SHALL be the `fwd_b_sel`-selected value. Operand B SHALL be Bfwd when `ALUSrc_in`=00, otherwise the immediate selected by `ALUSrc_in`.
- REQ-018 `ALU_ctrl_in` encodings SHALL be:
  - 0000 AND; 0001 OR; 0010 ADD (modulo 2^32, no trap); 0011 XOR; 0100 NOR
  - 0101 SLL B by `shamt_in`; 1000 SRL; 1001 SRA
  - 0110 SUB; 0111 SLT signed; 1010 SLTU unsigned; SLT and SLTU results are 0 or 1
  - 1011 MULTU; 1100 MFHI; 1101 MFLO; 1110 pass B; 1111 result 0
- REQ-019 Each non-stalled rising edge SHALL register:
  - `alu_result_out` = result
  - `write_data_out` = Bfwd
  - `write_reg_out` = `RegDst_in` ? `RD_in` : `RT_in`
  - the four memory/writeback control bits, passed through
- REQ-020 `branch_taken_out` SHALL register `Branch_in` AND (A == B).
- REQ-021 `branch_target_out` SHALL register `pc_plus_4_in` + (`sign_ext_imm_in` << 2), modulo 2^32.
- REQ-022 MULTU SHALL use an iterative shift-add multiplier with state machine IDLE -> BUSY -> DONE -> IDLE.
- REQ-023 IDLE with `ALU_ctrl_in`=1011: the block SHALL capture A and B, assert `stall_out`=1, and go to BUSY with count=0.
- REQ-024 BUSY SHALL take exactly 32 cycles with `stall_out`=1. At the edge ending the 32nd cycle, HI:LO SHALL be written with the 64-bit unsigned product and the state SHALL go to DONE.
- REQ-025 DONE SHALL hold `stall_out`=0 for one cycle while the MULTU retires, then go to IDLE.
- REQ-026 A MULTU SHALL therefore hold `stall_out`=1 for 33 consecutive cycles.
- REQ-027 On every edge where `stall_out`=1, and for the MULTU retiring in DONE, the block SHALL register a bubble:
  - `RegWrite_out`, `MemWrite_out`, `MemRead_out` and `branch_taken_out` = 0
  - data outputs = 0
- REQ-028 HI and LO SHALL change only at the end of BUSY. MFHI or MFLO issued immediately after DONE SHALL see the new product.
- REQ-029 Upstream SHALL hold all inputs stable while `stall_out`=1; changes to the inputs during BUSY SHALL NOT affect the product.
- REQ-030 Forwarding inputs SHALL take effect in the same cycle they are presented; no internal forwarding is performed.

Reset
- REQ-031 While `reset`=0, all registered outputs, HI and LO SHALL be 0, the state SHALL be IDLE, the multiplier counter SHALL be 0, and `stall_out` SHALL be 0 (an IDLE MULTU is not accepted).
- REQ-032 An assertion of `reset` mid-BUSY SHALL immediately abort the multiply. After release, HI and LO SHALL remain 0 until a new MULTU completes.
- REQ-033 Release of `reset` SHALL be synchronised externally; the first active edge after release processes the current inputs normally.

Verification
- REQ-034 ADD: A=5, B=7, `ALUSrc_in`=00 -> after 1 edge `alu_result_out`=12, `RegWrite_out` follows the input.
- REQ-035 Branch: A=B=0x10, SUB, `Branch_in`=1, `pc_plus_4_in`=0x100, `sign_ext_imm_in`=0xFFFFFFFF -> `branch_taken_out`=1, `branch_target_out`=0xFC.
- REQ-036 Forward plus SRA: `fwd_b_sel`=01, `ex_mem_fwd_data`=0x80000000, `shamt_in`=4 -> `alu_result_out`=0xF8000000.
- REQ-037 MULTU 0xFFFFFFFF × 2 -> `stall_out`=1 for exactly 33 cycles and bubbles emitted; a following MFHI gives 1 and MFLO gives 0xFFFFFFFE.
- REQ-038 Reset pulse in BUSY cycle 10 -> `stall_out`=0 immediately, all outputs 0, state IDLE; a following MFLO gives 0.
- REQ-039 A=0xFFFFFFFF, B=1 -> SLT gives 1 and SLTU gives 0; opcode 1111 gives 0.
